// File: rtl/bus_arb_mux.sv
// Registered N-source bus mux: direct select or round-robin arbitration feeding a one-word
// valid/ready output stage. Define BUS_ARB_LOCK_EN to add lock_in (holds the round-robin grant).
module bus_arb_mux #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 16,
    localparam int SEL_W = $clog2(N_SRC)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode_in,
    input  logic [SEL_W-1:0]        sel_in,
    input  logic [N_SRC-1:0]        req_in,
    input  logic [N_SRC*DATA_W-1:0] d_in,
    output logic [N_SRC-1:0]        gnt_out,
    output logic [DATA_W-1:0]       m_out,
    output logic [SEL_W-1:0]        src_out,
    output logic                    valid_out,
`ifdef BUS_ARB_LOCK_EN
    input  logic                    lock_in,
`endif
    input  logic                    ready_in
);

    logic [DATA_W-1:0] slices [N_SRC];
    logic [DATA_W-1:0] m_q;
    logic [SEL_W-1:0]  src_q;
    logic [SEL_W-1:0]  ptr_q;
    logic [SEL_W-1:0]  ptr_d;
    logic              valid_q;
    logic              canLoad;
    logic              lockActive;
    logic              grantFound;
    logic              rrAdvance;
    logic [SEL_W-1:0]  grantIdx;
    logic [SEL_W-1:0]  scanIdx;
    int                scanPos;

    for (genvar i = 0; i < N_SRC; i++) begin : g_slice
        assign slices[i] = d_in[i*DATA_W +: DATA_W];
    end

    assign canLoad = !valid_q || ready_in;

`ifdef BUS_ARB_LOCK_EN
    assign lockActive = lock_in;
`else
    assign lockActive = 1'b0;
`endif

    // Winner selection; the round-robin scan starts at ptr and wraps past N_SRC-1.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        rrAdvance  = 1'b0;
        scanIdx    = '0;
        scanPos    = 0;
        if (rst_n && canLoad) begin
            if (!mode_in) begin
                if (int'(sel_in) < N_SRC && req_in[sel_in]) begin
                    grantFound = 1'b1;
                    grantIdx   = sel_in;
                end
            end else if (lockActive) begin
                grantFound = req_in[src_q];
                grantIdx   = src_q;
            end else begin
                for (int k = 0; k < N_SRC; k++) begin
                    scanPos = int'(ptr_q) + k;
                    if (scanPos >= N_SRC) begin
                        scanPos = scanPos - N_SRC;
                    end
                    scanIdx = SEL_W'(scanPos);
                    if (!grantFound && req_in[scanIdx]) begin
                        grantFound = 1'b1;
                        grantIdx   = scanIdx;
                    end
                end
                rrAdvance = grantFound;
            end
        end
    end

    always_comb begin
        gnt_out = '0;
        if (grantFound) begin
            gnt_out[grantIdx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (rrAdvance) begin
            ptr_d = (int'(grantIdx) == N_SRC - 1) ? '0 : grantIdx + 1'b1;
        end
    end

    // A new word may overwrite the held one on the same edge it is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q     <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            if (canLoad) begin
                valid_q <= grantFound;
                if (grantFound) begin
                    m_q   <= slices[grantIdx];
                    src_q <= grantIdx;
                end
            end
        end
    end

    assign m_out     = m_q;
    assign src_out   = src_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Self-checking bench for bus_arb_mux: scoreboard of expected output words plus explicit
// grant expectations; a second N_SRC=3 instance covers the out-of-range direct select.
module tb_bus_arb_mux;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  src;
    } expWord_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic        ready;
    logic [1:0]  sel;
    logic [3:0]  req;
    logic [63:0] dBus;
    logic [3:0]  gnt;
    logic [15:0] mOut;
    logic [1:0]  srcOut;
    logic        validOut;
    logic [15:0] dataSlice [4];

    logic [1:0]  sel3;
    logic [2:0]  req3;
    logic [47:0] d3;
    logic [2:0]  gnt3;
    logic [15:0] m3;
    logic [1:0]  src3;
    logic        valid3;

`ifdef BUS_ARB_LOCK_EN
    logic lockDrv;
    logic lock3;
`endif

    expWord_t    sbQueue [$];
    expWord_t    popped;
    logic        modelValid;
    logic [15:0] modelM;
    logic [1:0]  modelSrc;
    int          testsRun = 0;
    int          testsFailed = 0;

    always #5 clk = ~clk;

    assign dBus = {dataSlice[3], dataSlice[2], dataSlice[1], dataSlice[0]};
    assign d3   = dBus[47:0];

    bus_arb_mux #(.N_SRC(4), .DATA_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode_in  (mode),
        .sel_in   (sel),
        .req_in   (req),
        .d_in     (dBus),
        .gnt_out  (gnt),
        .m_out    (mOut),
        .src_out  (srcOut),
        .valid_out(validOut),
`ifdef BUS_ARB_LOCK_EN
        .lock_in  (lockDrv),
`endif
        .ready_in (ready)
    );

    bus_arb_mux #(.N_SRC(3), .DATA_W(16)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode_in  (1'b0),
        .sel_in   (sel3),
        .req_in   (req3),
        .d_in     (d3),
        .gnt_out  (gnt3),
        .m_out    (m3),
        .src_out  (src3),
        .valid_out(valid3),
`ifdef BUS_ARB_LOCK_EN
        .lock_in  (lock3),
`endif
        .ready_in (1'b1)
    );

    // Counts every comparison and reports the ones that disagree.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One cycle: drive inputs, check the combinational grant, queue the word it should load,
    // then after the edge pop the queue into the output model and compare the registered outputs.
    task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] r,
                                 input logic rdy, input logic [3:0] expG, input string tag);
        int idx;
        mode  = m;
        sel   = s;
        req   = r;
        ready = rdy;
        #1;
        checkOutput({tag, "/gnt"}, 32'(gnt), 32'(expG));
        if (expG != 4'b0000) begin
            idx = 0;
            for (int i = 0; i < 4; i++) begin
                if (expG[i]) idx = i;
            end
            sbQueue.push_back('{data: dataSlice[idx], src: 2'(idx)});
        end
        @(posedge clk);
        #1;
        if (expG != 4'b0000 && sbQueue.size() > 0) begin
            popped     = sbQueue.pop_front();
            modelM     = popped.data;
            modelSrc   = popped.src;
            modelValid = 1'b1;
        end else if (!modelValid || rdy) begin
            modelValid = 1'b0;
        end
        checkOutput({tag, "/valid"}, 32'(validOut), 32'(modelValid));
        checkOutput({tag, "/m"}, 32'(mOut), 32'(modelM));
        checkOutput({tag, "/src"}, 32'(srcOut), 32'(modelSrc));
    endtask

    initial begin
        rst_n = 1'b0;
        mode  = 1'b1;
        sel   = 2'd0;
        req   = 4'b0000;
        ready = 1'b1;
        sel3  = 2'd0;
        req3  = 3'b000;
`ifdef BUS_ARB_LOCK_EN
        lockDrv = 1'b0;
        lock3   = 1'b0;
`endif
        for (int i = 0; i < 4; i++) dataSlice[i] = 16'h1000 + 16'(i);
        modelValid = 1'b0;
        modelM     = 16'h0000;
        modelSrc   = 2'd0;

        #3;
        checkOutput("reset/valid", 32'(validOut), 32'd0);
        checkOutput("reset/m", 32'(mOut), 32'd0);
        checkOutput("reset/gnt", 32'(gnt), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Round-robin fairness over all four sources, wrapping back to 0.
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, "rr0");
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, "rr1");
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, "rr2");
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, "rr3");
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, "rr4");

        // Asynchronous reset in the middle of a cycle while the stream is live.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midReset/valid", 32'(validOut), 32'd0);
        checkOutput("midReset/m", 32'(mOut), 32'd0);
        checkOutput("midReset/gnt", 32'(gnt), 32'd0);
        checkOutput("midReset/src", 32'(srcOut), 32'd0);
        sbQueue.delete();
        modelValid = 1'b0;
        modelM     = 16'h0000;
        modelSrc   = 2'd0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, "postReset");

        // Backpressure: word held while ready is low, then reload on the draining edge.
        applyStimulus(1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, "bpLoad");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd0, 4'b0110, 1'b0, 4'b0000, "bpHold");
        applyStimulus(1'b1, 2'd0, 4'b0110, 1'b1, 4'b0010, "bpRelease");

        // Direct select, then idle; the following round-robin grant shows ptr was untouched.
        dataSlice[2] = 16'hBEEF;
        applyStimulus(1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, "direct");
        applyStimulus(1'b0, 2'd2, 4'b0000, 1'b1, 4'b0000, "directIdle");
        dataSlice[2] = 16'h1002;
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, "ptrKept");

        // Sparse requests with ptr at 3: must wrap to 0, then move on to 1.
        applyStimulus(1'b1, 2'd0, 4'b0011, 1'b1, 4'b0001, "wrap0");
        applyStimulus(1'b1, 2'd0, 4'b0011, 1'b1, 4'b0010, "wrap1");

`ifdef BUS_ARB_LOCK_EN
        // Lock on source 1: others wait and ptr stays at 2 until lock drops.
        applyStimulus(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, "lockGrant");
        lockDrv = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, "locked");
        lockDrv = 1'b0;
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, "unlocked");
`endif

        // Three-source instance: select index 3 is out of range, so nothing is granted.
        sel3 = 2'd0;
        req3 = 3'b001;
        #1;
        checkOutput("n3/gnt0", 32'(gnt3), 32'b001);
        @(posedge clk);
        #1;
        checkOutput("n3/valid0", 32'(valid3), 32'd1);
        checkOutput("n3/m0", 32'(m3), 32'h1000);
        checkOutput("n3/src0", 32'(src3), 32'd0);
        sel3 = 2'd3;
        req3 = 3'b111;
        #1;
        checkOutput("n3/gntOut", 32'(gnt3), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("n3/validDrop", 32'(valid3), 32'd0);
        checkOutput("n3/mHeld", 32'(m3), 32'h1000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
